// File: rtl/matmul_lanes.sv
// Square matrix-multiply controller: LANES MAC lanes compute one row group of C per output
// column, sharing one B operand per cycle; saturated results are written serially to the C RAM.
module matmul_lanes #(
  parameter int DIM    = 8,
  parameter int LANES  = 2,
  parameter int DW     = 8,
  parameter int OUTW   = 19,
  parameter int RD_LAT = 1,
  parameter int AW     = $clog2(DIM*DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count,
  output logic [LANES*AW-1:0]   a_addr,
  input  logic [LANES*DW-1:0]   a_data,
  output logic [AW-1:0]         b_addr,
  input  logic [DW-1:0]         b_data,
  output logic                  c_we,
  output logic [AW-1:0]         c_addr,
  output logic [OUTW-1:0]       c_data
);
  localparam int ACCW = 2*DW + $clog2(DIM);
  localparam int PW   = 2*DW;
  localparam int NG   = DIM / LANES;
  localparam int KW   = $clog2(DIM);
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW   = (OUTW > ACCW) ? OUTW : ACCW;

  localparam logic [KW-1:0] K_LAST = KW'(DIM-1);
  localparam logic [GW-1:0] G_LAST = GW'(NG-1);
  localparam logic [LW-1:0] L_LAST = LW'(LANES-1);
  localparam logic [2:0]    F_LAST = 3'(RD_LAT-1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) << (OUTW-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(longint'(1) << (OUTW-1)));

  // Clamp to OUTW; when OUTW covers ACCW the bounds are never reached and this is a sign-extend.
  function automatic logic signed [OUTW-1:0] sat(input logic signed [ACCW-1:0] x);
    logic signed [SW-1:0] xe;
    xe = SW'(x);
    if (xe > SAT_MAX)      xe = SAT_MAX;
    else if (xe < SAT_MIN) xe = SAT_MIN;
    return OUTW'(xe);
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FLUSH, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d, c_q, c_d;
  logic [GW-1:0]           g_q, g_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [2:0]              fl_q, fl_d;
  logic                    clr, start_acc;
  logic [RD_LAT-1:0]       vld_q;
  logic signed [ACCW-1:0]  acc_q [LANES];
  logic signed [ACCW-1:0]  acc_d [LANES];
  logic signed [ACCW-1:0]  c_sel;
  logic signed [PW-1:0]    a_ext, b_ext;

  logic                    busy_q, done_q, c_we_q;
  logic [31:0]             cc_q;
  logic [LANES*AW-1:0]     a_addr_q, a_addr_d;
  logic [AW-1:0]           b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic signed [OUTW-1:0]  c_data_q, c_data_d;

  assign start_acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    c_d     = c_q;
    lane_d  = lane_q;
    fl_d    = fl_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          g_d     = '0;
          c_d     = '0;
          clr     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_FLUSH;
          fl_d    = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (fl_q == F_LAST) begin
          state_d = S_WRITE;
          lane_d  = '0;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (lane_q == L_LAST) begin
          clr     = 1'b1;
          k_d     = '0;
          state_d = S_ISSUE;
          if (g_q == G_LAST) begin
            g_d = '0;
            if (c_q == K_LAST) state_d = S_DONE;
            else               c_d = c_q + 1'b1;
          end else begin
            g_d = g_q + 1'b1;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC stage: operands arrive RD_LAT cycles after their issue cycle, tracked by vld_q.
  always_comb begin
    a_ext = '0;
    b_ext = PW'($signed(b_data));
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
      a_ext    = PW'($signed(a_data[l*DW +: DW]));
      if (vld_q[RD_LAT-1]) acc_d[l] = acc_q[l] + ACCW'(a_ext * b_ext);
      if (clr)             acc_d[l] = '0;
    end
  end

  // Outputs are registered from the next state; the first write lane sees the final product via acc_d.
  always_comb begin
    a_addr_d = '0;
    b_addr_d = '0;
    c_addr_d = '0;
    c_data_d = '0;
    c_sel    = '0;
    if (state_d == S_ISSUE) begin
      for (int l = 0; l < LANES; l++)
        a_addr_d[l*AW +: AW] = AW'((int'(g_d) * LANES + l) * DIM + int'(k_d));
      b_addr_d = AW'(int'(k_d) * DIM + int'(c_d));
    end
    if (state_d == S_WRITE) begin
      for (int l = 0; l < LANES; l++)
        if (lane_d == LW'(l)) c_sel = acc_d[l];
      c_addr_d = AW'((int'(g_d) * LANES + int'(lane_d)) * DIM + int'(c_d));
      c_data_d = sat(c_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      g_q      <= '0;
      c_q      <= '0;
      lane_q   <= '0;
      fl_q     <= '0;
      vld_q    <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_we_q   <= 1'b0;
      cc_q     <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      g_q      <= g_d;
      c_q      <= c_d;
      lane_q   <= lane_d;
      fl_q     <= fl_d;
      vld_q    <= RD_LAT'({vld_q, state_q == S_ISSUE});
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
      busy_q   <= (state_d == S_ISSUE) || (state_d == S_FLUSH) || (state_d == S_WRITE);
      done_q   <= (state_d == S_DONE);
      c_we_q   <= (state_d == S_WRITE);
      if (start_acc)                  cc_q <= '0;
      else if (busy_q && cc_q != '1)  cc_q <= cc_q + 32'd1;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cc_q;
  assign a_addr      = a_addr_q;
  assign b_addr      = b_addr_q;
  assign c_we        = c_we_q;
  assign c_addr      = c_addr_q;
  assign c_data      = c_data_q;

endmodule

// File: doc/matmul_lanes.md
# matmul_lanes

Parametrised square matrix-multiply controller computing C = A × B for DIM×DIM signed matrices held in external synchronous RAMs. LANES multiply-accumulate lanes each compute one row of a LANES-row group for the current output column, sharing one B operand per cycle. Results are saturated to OUTW bits and written serially into the C RAM. It replaces the fixed 8×8, two-lane controller and adds configurable lanes, read latency, saturation and a repeatable start/done handshake.

## Interface
- DIM, 8: matrix dimension; power of two, ≥2
- LANES, 2: parallel MAC lanes; must divide DIM
- DW, 8: signed element width of A and B
- OUTW, 19: signed width of C elements; results saturate to this width
- RD_LAT, 1: A/B RAM read latency in cycles (1..4)
- AW, clog2(DIM*DIM): RAM address width
- ACCW, 2*DW+clog2(DIM): internal accumulator width (derived, not overridable)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a multiply; sampled only in IDLE
- busy  out  1  high in ISSUE/FLUSH/WRITE
- done  out  1  one-cycle pulse when C is complete
- cycle_count  out  32  cycles spent in ISSUE/FLUSH/WRITE for the last/current run
- a_addr  out  LANES*AW  lane l address in bits [l*AW +: AW]
- a_data  in  LANES*DW  lane l data, valid RD_LAT cycles after its address
- b_addr  out  AW  shared B address
- b_data  in  DW  B data, valid RD_LAT cycles after b_addr
- c_we  out  1  C write strobe
- c_addr  out  AW  C write address
- c_data  out  OUTW  saturated result

## Operation
- Storage row-major in all RAMs: A[r][k] at r*DIM+k, B[k][c] at k*DIM+c, C[r][c] at r*DIM+c.
- Traversal: outer loop column c = 0..DIM-1; inner loop row group g = 0..DIM/LANES-1; one tile per (c,g).
- States: IDLE, ISSUE, FLUSH, WRITE, DONE.
- IDLE: outputs quiescent; start=1 → ISSUE with c=g=k=0, accumulators cleared, cycle_count cleared.
- ISSUE (DIM cycles, k=0..DIM-1): a_addr lane l = (g*LANES+l)*DIM+k; b_addr = k*DIM+c. After k=DIM-1 → FLUSH.
- Valid pipeline: RD_LAT-deep shift register of issue-valid; when its output is high, every lane does acc_l += a_data_l * b_data (signed, full ACCW, no overflow possible).
- FLUSH (RD_LAT cycles): no issue; lets last products accumulate → WRITE.
- WRITE (LANES cycles, lane l=0..LANES-1): c_we=1, c_addr=(g*LANES+l)*DIM+c, c_data=sat(acc_l). Last lane: clear all accumulators; advance g, wrapping to 0 and advancing c; if last tile → DONE else → ISSUE.
- sat(x): x > 2^(OUTW-1)-1 → 2^(OUTW-1)-1; x < -2^(OUTW-1) → -2^(OUTW-1); else x. If OUTW ≥ ACCW, pass-through sign-extended.
- DONE (1 cycle): done=1, busy=0 → IDLE. cycle_count holds its final value until next accepted start.
- start while busy or in DONE: ignored.

## Timing
- Reset values: busy=0, done=0, cycle_count=0, c_we=0, a_addr=0, b_addr=0, c_addr=0, c_data=0; state IDLE; accumulators and valid pipeline cleared.
- Reset mid-run: next cycle all of the above; no further c_we; partial C contents undefined.
- All outputs registered. start high in IDLE at edge t → busy=1 and first ISSUE addresses from t+1.
- Per-tile cycles: DIM + RD_LAT + LANES. Total cycle_count = DIM*(DIM/LANES)*(DIM+RD_LAT+LANES).
- done is asserted in the cycle after the final c_we; exactly DIM*DIM c_we pulses per run, each address written once.
- cycle_count increments once per cycle while busy; it saturates at 2^32-1.
- Back-to-back: start may be high during the DONE cycle but is ignored; earliest restart is the following IDLE cycle.

## Test plan
- DIM=8, LANES=2, RD_LAT=1, A=identity, B[k][c]=k*8+c → C equals B; 64 writes in c-major order; cycle_count=352; one done pulse.
- A and B all 127 with OUTW=16 (DIM=8) → every C = 32767 (saturated, true 129032); all -128 × 127 → every C = -32768.
- LANES=4, RD_LAT=2, random signed A/B vs. reference model → bit-exact C; cycle_count = 8*2*14 = 224.
- LANES=1 and LANES=DIM configs, random data → correct C; cycle_count 8*8*10 = 640 and 8*1*17 = 136.
- reset asserted for 1 cycle mid-ISSUE of tile 5 → busy=0, c_we=0 next cycle; new start produces fully correct C.
- start held high for the entire run → single run, single done pulse; run restarts only from IDLE after DONE.
